fpga_system_nios2_ocimem_arbiter: RTL
=====================================

// Module: fpga_system_nios2_ocimem_arbiter
// PURPOSE
// - Arbitrates the Nios II on-chip debug memory (monitor RAM) between two requesters: the JTAG debug
//   command path (sysclk side of the debug slave) and the CPU Avalon-MM debug_mem slave.
// - Serialises single-word accesses onto one single-port RAM with 1-cycle read latency.
// - Gives JTAG fixed priority while the CPU is halted (debugack=1); round-robin otherwise.
// PARAMETERS
// - ADDR_W     8       word address width of monitor RAM
// - DATA_W     32      data width (multiple of 8)
// - PROT_BASE  8'hE0   first write-protected word address (used only with NIOS_OCIMEM_WRPROT_EN)
// PORTS
// - clk              in   1         system clock; all logic on rising edge
// - reset            in   1         synchronous, active-high reset
// - debugack         in   1         CPU halted in debug mode
// - jtag_cmd_valid   in   1         JTAG command request (level; held until accepted)
// - jtag_cmd_write   in   1         1=write, 0=read
// - jtag_cmd_addr    in   ADDR_W    JTAG word address
// - jtag_cmd_wdata   in   DATA_W    JTAG write data (all bytes written)
// - jtag_cmd_ready   out  1         JTAG command accepted this cycle
// - jtag_rsp_valid   out  1         one-cycle pulse: jtag_rsp_data valid
// - jtag_rsp_data    out  DATA_W    JTAG read result (MonDReg source), held until next JTAG read
// - avs_address      in   ADDR_W    CPU word address
// - avs_read         in   1         CPU read request
// - avs_write        in   1         CPU write request (read and write never both high)
// - avs_writedata    in   DATA_W    CPU write data
// - avs_byteenable   in   DATA_W/8  CPU byte enables
// - avs_waitrequest  out  1         low only in the cycle the CPU request is accepted
// - avs_readdata     out  DATA_W    CPU read result, held until next CPU read
// - avs_readdatavalid out 1         one-cycle pulse: avs_readdata valid
// - ram_addr/ram_wren/ram_byteen/ram_wdata  out  ADDR_W/1/DATA_W/8/DATA_W  registered RAM controls
// - ram_rdata        in   DATA_W    RAM read data, valid 1 cycle after address
// - prot_err         out  1         sticky protected-write flag
// BEHAVIOUR
// - States: IDLE, ACCESS, CAPTURE. Reset -> IDLE; all outputs 0 except avs_waitrequest=1;
//   last_grant=JTAG, readdata/rsp_data=0.
// - IDLE (cycle N): arbitrate; winner's ready/waitrequest asserted combinationally; command latched
//   into ram_* regs; -> ACCESS. No request: stay IDLE, waitrequest=1, ready=0.
// - Arbitration: debugack=1 -> JTAG wins any contention. debugack=0 -> contention goes to requester
//   not in last_grant; last_grant updated on every grant. Single requester always wins.
// - ACCESS (N+1): ram_* driven; ram_wren=1 only for writes (JTAG: byteen all-ones).
//   Write -> IDLE at N+2. Read -> CAPTURE.
// - CAPTURE (N+2): ram_rdata registered into owner's data reg; owner's valid pulses at N+3; -> IDLE.
// - Throughput: write every 2 cycles, read every 3; read latency accept->valid = 3 cycles.
// - No accept outside IDLE; loser's request held by requester, serviced in next IDLE.
// - ram_wren/ram_byteen cleared in every non-ACCESS cycle; ram_addr holds last value.
// - Reset mid-transaction: -> IDLE next cycle; in-flight read discarded (no valid pulse);
//   ram_wren=0; held data regs cleared to 0.
// - Address is word-indexed; no wrap or range check (ADDR_W covers full RAM).
// CONFIGURATION
// - NIOS_OCIMEM_WRPROT_EN defined: CPU write with avs_address>=PROT_BASE while debugack=0 is
//   accepted (waitrequest low, normal timing) but ram_wren stays 0 and prot_err sets; prot_err
//   clears only on reset. JTAG writes and debugack=1 CPU writes are never blocked.
// - Not defined: all writes reach RAM; prot_err tied 0; PROT_BASE unused.
// TESTING
// - JTAG write addr 0x10 data 0xDEADBEEF, then read 0x10 -> ram_wren 1 cycle; jtag_rsp_valid 3 cycles
//   after accept, jtag_rsp_data=0xDEADBEEF.
// - CPU read/write simultaneous with JTAG, debugack=0, four back-to-back pairs -> grants alternate
//   CPU,JTAG,CPU,JTAG; no request lost.
// - Same contention with debugack=1 -> JTAG granted every contention; CPU served only when JTAG idle.
// - CPU write byteenable 4'b0101 data 0x11223344 over 0xFFFFFFFF, read back -> 0xFF22FF44.
// - Reset asserted in CAPTURE of CPU read -> no avs_readdatavalid, IDLE next cycle, avs_readdata=0.
// - WRPROT_EN: CPU write 0xE5 debugack=0 -> no ram_wren, prot_err=1; same with debugack=1 -> written.

Source files
------------

// File: rtl/fpga_system_nios2_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpga_system_nios2_ocimem_arbiter
// Description : Shares the Nios II on-chip debug (monitor) RAM between the
//               JTAG debug command path and the CPU debug_mem Avalon slave.
//               One single-word access at a time onto a single-port RAM with
//               1-cycle read latency. JTAG has fixed priority while the CPU
//               is halted (debugack=1); round-robin otherwise.
//               Optional feature macro: NIOS_OCIMEM_WRPROT_EN -- blocks CPU
//               writes at or above PROT_BASE while the CPU is running and
//               raises a sticky prot_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_system_nios2_ocimem_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] PROT_BASE = 8'hE0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  debugack,
    // JTAG debug command path
    input  logic                  jtag_cmd_valid,
    input  logic                  jtag_cmd_write,
    input  logic [ADDR_W-1:0]     jtag_cmd_addr,
    input  logic [DATA_W-1:0]     jtag_cmd_wdata,
    output logic                  jtag_cmd_ready,
    output logic                  jtag_rsp_valid,
    output logic [DATA_W-1:0]     jtag_rsp_data,
    // CPU Avalon-MM debug_mem slave
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    // Monitor RAM port
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_wren,
    output logic [DATA_W/8-1:0]   ram_byteen,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  prot_err
);

`ifdef NIOS_OCIMEM_WRPROT_EN
    localparam logic c_WRPROT_EN = 1'b1;
`else
    localparam logic c_WRPROT_EN = 1'b0;
`endif

    localparam int       c_BE_W     = DATA_W / 8;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACCESS  = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic     c_GNT_JTAG = 1'b0;
    localparam logic     c_GNT_CPU  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic              is_read_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wren_q;
    logic [c_BE_W-1:0] ram_byteen_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              jtag_rsp_valid_q;
    logic [DATA_W-1:0] jtag_rsp_data_q;
    logic              avs_rdv_q;
    logic [DATA_W-1:0] avs_readdata_q;
    logic              prot_err_q;

    logic w_jtag_req;
    logic w_cpu_req;
    logic w_idle;
    logic w_grant_jtag;
    logic w_grant_cpu;
    logic w_prot_hit;

    assign w_jtag_req = jtag_cmd_valid;
    assign w_cpu_req  = avs_read | avs_write;
    // No grant is ever issued while reset is held, so waitrequest stays high.
    assign w_idle     = (state_q == c_IDLE) && !reset;

    // Arbitration: fixed JTAG priority when halted, alternate otherwise.
    always_comb begin
        w_grant_jtag = 1'b0;
        w_grant_cpu  = 1'b0;
        if (w_idle) begin
            if (w_jtag_req && w_cpu_req) begin
                if (debugack || (last_grant_q == c_GNT_CPU)) begin
                    w_grant_jtag = 1'b1;
                end else begin
                    w_grant_cpu  = 1'b1;
                end
            end else if (w_jtag_req) begin
                w_grant_jtag = 1'b1;
            end else if (w_cpu_req) begin
                w_grant_cpu  = 1'b1;
            end
        end
    end

    // A running CPU may not modify the protected top region of the RAM.
    assign w_prot_hit = c_WRPROT_EN && w_grant_cpu && avs_write && !debugack &&
                        (avs_address >= PROT_BASE);

    // Sequencing: IDLE -> ACCESS -> (reads only) CAPTURE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:    if (w_grant_jtag || w_grant_cpu) state_d = c_ACCESS;
            c_ACCESS:  state_d = is_read_q ? c_CAPTURE : c_IDLE;
            c_CAPTURE: state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    // Latch the winning command into the RAM controls and capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= c_IDLE;
            last_grant_q     <= c_GNT_JTAG;
            owner_q          <= c_GNT_JTAG;
            is_read_q        <= 1'b0;
            ram_addr_q       <= '0;
            ram_wren_q       <= 1'b0;
            ram_byteen_q     <= '0;
            ram_wdata_q      <= '0;
            jtag_rsp_valid_q <= 1'b0;
            jtag_rsp_data_q  <= '0;
            avs_rdv_q        <= 1'b0;
            avs_readdata_q   <= '0;
            prot_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            // Write strobes only live during the ACCESS cycle.
            ram_wren_q       <= 1'b0;
            ram_byteen_q     <= '0;
            jtag_rsp_valid_q <= 1'b0;
            avs_rdv_q        <= 1'b0;

            if (w_grant_jtag) begin
                last_grant_q <= c_GNT_JTAG;
                owner_q      <= c_GNT_JTAG;
                is_read_q    <= !jtag_cmd_write;
                ram_addr_q   <= jtag_cmd_addr;
                ram_wdata_q  <= jtag_cmd_wdata;
                ram_byteen_q <= '1;
                ram_wren_q   <= jtag_cmd_write;
            end else if (w_grant_cpu) begin
                last_grant_q <= c_GNT_CPU;
                owner_q      <= c_GNT_CPU;
                is_read_q    <= avs_read;
                ram_addr_q   <= avs_address;
                ram_wdata_q  <= avs_writedata;
                ram_byteen_q <= avs_byteenable;
                ram_wren_q   <= avs_write && !w_prot_hit;
                if (w_prot_hit) begin
                    prot_err_q <= 1'b1;
                end
            end

            if (state_q == c_CAPTURE) begin
                if (owner_q == c_GNT_JTAG) begin
                    jtag_rsp_data_q  <= ram_rdata;
                    jtag_rsp_valid_q <= 1'b1;
                end else begin
                    avs_readdata_q   <= ram_rdata;
                    avs_rdv_q        <= 1'b1;
                end
            end
        end
    end

    assign jtag_cmd_ready    = w_grant_jtag;
    assign avs_waitrequest   = !w_grant_cpu;
    assign jtag_rsp_valid    = jtag_rsp_valid_q;
    assign jtag_rsp_data     = jtag_rsp_data_q;
    assign avs_readdata      = avs_readdata_q;
    assign avs_readdatavalid = avs_rdv_q;
    assign ram_addr          = ram_addr_q;
    assign ram_wren          = ram_wren_q;
    assign ram_byteen        = ram_byteen_q;
    assign ram_wdata         = ram_wdata_q;
    assign prot_err          = c_WRPROT_EN & prot_err_q;

endmodule
`default_nettype wire
